// File: rtl/fetch_queue.sv
// fetch_queue: instruction queue between the fetch and decode stages.
// Holds {PC+4, instruction} pairs in FIFO order; a full queue deasserts
// fetch_ready, which the top level uses as the fetch stage's pc_enable.
// Optional build macro FETCHQ_BYPASS_EN: when defined, an empty queue
// forwards the fetch pair straight to decode in the same cycle.
module fetch_queue #(
  parameter int ADDR_BITS  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  fetch_valid,
  input  logic [ADDR_BITS-1:0]  fetch_pc,
  input  logic [DATA_WIDTH-1:0] fetch_instr,
  output logic                  fetch_ready,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [ADDR_BITS-1:0]  dec_pc,
  output logic [DATA_WIDTH-1:0] dec_instr,
  output logic [PTR_BITS:0]     level
);

  localparam logic [PTR_BITS:0]   FULL_COUNT = (PTR_BITS+1)'(DEPTH);
  localparam logic [PTR_BITS:0]   COUNT_ONE  = (PTR_BITS+1)'(1);
  localparam logic [PTR_BITS-1:0] PTR_ONE    = PTR_BITS'(1);

  logic [ADDR_BITS-1:0]  pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr;
  logic [PTR_BITS-1:0]   rd_ptr;
  logic [PTR_BITS:0]     count;
  logic                  push;
  logic                  pop;
  logic                  bypass_active;

  // Handshake and head-of-queue view; fetch_ready only ever looks at count
  // so a stalled decode cannot create a loop back into the fetch stage.
  always_comb begin
    fetch_ready   = (count != FULL_COUNT);
    level         = count;
    bypass_active = 1'b0;
    dec_valid     = (count != '0);
    dec_pc        = pc_mem[rd_ptr];
    dec_instr     = instr_mem[rd_ptr];
`ifdef FETCHQ_BYPASS_EN
    bypass_active = (count == '0) && !flush;
    if (bypass_active) begin
      dec_valid = fetch_valid;
      dec_pc    = fetch_pc;
      dec_instr = fetch_instr;
    end
`endif
    // A bypassed pair consumed by decode this cycle is never written.
    push = fetch_valid && fetch_ready && !(bypass_active && dec_ready);
    pop  = dec_valid && dec_ready && !bypass_active;
  end

  // Pointer, occupancy and storage update; flush outranks push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= fetch_pc;
        instr_mem[wr_ptr] <= fetch_instr;
        wr_ptr            <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + COUNT_ONE;
      end else if (pop && !push) begin
        count <= count - COUNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue. A queue of expected
// {pc, instr} pairs models the FIFO; a negedge monitor compares the DUT's
// decode-side outputs and occupancy against it. Follows FETCHQ_BYPASS_EN.
module tb_fetch_queue;

  localparam int ADDR_BITS  = 32;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 4;
  localparam int PTR_BITS   = 2;
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  flush = 1'b0;
  logic                  fetch_valid = 1'b0;
  logic [ADDR_BITS-1:0]  fetch_pc = '0;
  logic [DATA_WIDTH-1:0] fetch_instr = '0;
  logic                  fetch_ready;
  logic                  dec_valid;
  logic                  dec_ready = 1'b0;
  logic [ADDR_BITS-1:0]  dec_pc;
  logic [DATA_WIDTH-1:0] dec_instr;
  logic [PTR_BITS:0]     level;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q [$];

  fetch_queue #(
    .ADDR_BITS(ADDR_BITS), .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(DEPTH), .PTR_BITS(PTR_BITS)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .fetch_ready(fetch_ready), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_instr(dec_instr), .level(level)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkField(input string name, input logic [63:0] act,
                            input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
    end
  endtask

  // Compare DUT outputs against the model's current view of the queue.
  task automatic checkOutput();
    int size;
    logic exp_valid;
    logic [63:0] head;
    size = exp_q.size();
    checkField("fetch_ready", 64'(fetch_ready), 64'(size < DEPTH));
    checkField("level", 64'(level), 64'(size));
    exp_valid = (size != 0);
    head = (size != 0) ? exp_q[0] : 64'h0;
    if (BYPASS && size == 0 && !flush) begin
      exp_valid = fetch_valid;
      head = {fetch_pc, fetch_instr};
    end
    checkField("dec_valid", 64'(dec_valid), 64'(exp_valid));
    if (exp_valid && dec_valid) begin
      checkField("dec_pc", 64'(dec_pc), 64'(head[63:32]));
      checkField("dec_instr", 64'(dec_instr), 64'(head[31:0]));
    end
  endtask

  // Advance the model across the coming rising edge using the held inputs.
  task automatic updateModel();
    int size;
    bit take_direct;
    bit do_pop;
    bit do_push;
    size = exp_q.size();
    if (flush) begin
      exp_q.delete();
    end else begin
      take_direct = BYPASS && size == 0 && fetch_valid && dec_ready;
      do_pop  = (size != 0) && dec_ready;
      do_push = fetch_valid && (size < DEPTH) && !take_direct;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({fetch_pc, fetch_instr});
    end
  endtask

  // Monitor: sample away from the active edge, check, then step the model.
  always @(negedge clk) begin
    if (reset) begin
      checkField("rst_dec_valid", 64'(dec_valid), 64'h0);
      checkField("rst_fetch_ready", 64'(fetch_ready), 64'h1);
      checkField("rst_level", 64'(level), 64'h0);
    end else begin
      checkOutput();
      updateModel();
    end
  end

  // Hold the given inputs through the next rising edge.
  task automatic applyStimulus(input logic fv, input logic [31:0] pc,
                               input logic [31:0] instr, input logic dr,
                               input logic fl);
    fetch_valid = fv;
    fetch_pc    = pc;
    fetch_instr = instr;
    dec_ready   = dr;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle after reset: outputs stay at reset values, storage reads zero.
    repeat (3) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkField("idle_dec_pc", 64'(dec_pc), 64'h0);
    checkField("idle_dec_instr", 64'(dec_instr), 64'h0);

    // Single pass-through.
    applyStimulus(1'b1, 32'h4, 32'h20080005, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill with decode stalled, then an ignored push, then drain.
    for (int i = 1; i <= 5; i++)
      applyStimulus(1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Wrap-around: streaming 10 entries with decode always ready.
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with three entries and a simultaneous push.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h200 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h40, 32'hC000_0040, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h44, 32'hC000_0044, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges with two entries held.
    applyStimulus(1'b1, 32'h300, 32'hD000_0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h304, 32'hD000_0001, 1'b0, 1'b0);
    fetch_valid = 1'b0;
    #1;
    checkField("pre_reset_level", 64'(level), 64'h2);
    reset = 1'b1;
    #1;
    checkField("async_dec_valid", 64'(dec_valid), 64'h0);
    checkField("async_level", 64'(level), 64'h0);
    exp_q.delete();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 99) < 60), $urandom, $urandom,
                    1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 4));
    for (int i = 0; i < DEPTH + 2; i++)
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue directly downstream of the fetch stage; captures each fetched {PC+4, instruction} pair and presents it to the decode stage.
- Decouples decode stalls from the fetch stage: a full queue deasserts fetch_ready, which the top level wires to the fetch stage's pc_enable.
- A branch resolved later in the pipeline flushes the queue.

Parameters:
ADDR_BITS, 32, width of the PC+4 value carried per entry
DATA_WIDTH, 32, width of the instruction word per entry
DEPTH, 4, number of entries; power of two, minimum 2
PTR_BITS, 2, log2(DEPTH); must match DEPTH

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous discard of all entries (branch taken)
fetch_valid  input  1  fetch stage presents a valid pair this cycle
fetch_pc  input  ADDR_BITS  PC+4 from the fetch stage
fetch_instr  input  DATA_WIDTH  instruction word from the fetch stage
fetch_ready  output  1  queue accepts a push this cycle; drives pc_enable
dec_valid  output  1  head entry valid for decode
dec_ready  input  1  decode consumes the head entry this cycle
dec_pc  output  ADDR_BITS  PC+4 of the head entry
dec_instr  output  DATA_WIDTH  instruction of the head entry
level  output  PTR_BITS+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH x (ADDR_BITS+DATA_WIDTH) register array. wr_ptr and rd_ptr are PTR_BITS wide and wrap modulo DEPTH. A separate count register is PTR_BITS+1 wide.
- Reset (async): wr_ptr=0, rd_ptr=0, count=0, all storage=0. Reset values: fetch_ready=1, dec_valid=0, dec_pc=0, dec_instr=0, level=0.
- push = fetch_valid & fetch_ready.
- pop = dec_valid & dec_ready.
- fetch_ready = (count != DEPTH). It is combinational from state only and never depends on dec_ready. A full queue refuses a push even while a pop occurs in the same cycle.
- dec_valid = (count != 0).
- dec_pc and dec_instr are read show-ahead from the entry at rd_ptr. They hold their value while dec_valid=1 and dec_ready=0.
- Push: write the entry at wr_ptr, then wr_ptr+1.
- Pop: rd_ptr+1.
- Count update: push only +1; pop only -1; push and pop together leave count unchanged (legal whenever 0 < count < DEPTH).
- Latency: a pair pushed at edge N is visible at the decode outputs in the cycle after edge N (one cycle). This applies even when the queue was empty.
- Flush has the highest priority among synchronous events. At the next edge: count=0, rd_ptr=0, wr_ptr=0. Any push and pop in that cycle are discarded, and storage is not cleared. In the cycle after the flush edge, dec_valid=0 and fetch_ready=1.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. Ordering is strictly FIFO.
- fetch_valid=1 while fetch_ready=0: the input is ignored, and the fetch stage holds its PC because pc_enable=0.
- Reset asserted mid-stream: state clears immediately, without waiting for a clock edge.
- level equals count.

Optional Feature:
FETCHQ_BYPASS_EN
- Defined:
  - When count==0 and flush==0, dec_valid = fetch_valid.
  - In that case dec_pc and dec_instr are driven combinationally from fetch_pc and fetch_instr.
  - If dec_ready=1 in that cycle, the pair is consumed directly: no write, and pointers and count are unchanged.
  - If dec_ready=0, the pair is pushed normally.
  - Result: zero-cycle latency through an empty queue.
- Not defined: no combinational path from the fetch inputs to the decode outputs; the one-cycle latency rule applies.

Test Plan:
- Reset, then idle: fetch_valid=0 for 3 cycles -> dec_valid=0, fetch_ready=1, level=0, dec_pc=0.
- Single pass-through: push {pc=0x4, instr=0x20080005} with dec_ready=1 -> one cycle later dec_valid=1, dec_pc=0x4, dec_instr=0x20080005; next cycle dec_valid=0.
- Fill with dec_ready=0: push pc 0x4, 0x8, 0xC, 0x10 -> level=4, fetch_ready=0; push attempt with pc=0x14 ignored; release dec_ready -> pops return 0x4, 0x8, 0xC, 0x10 in order.
- Wrap-around: continuous push and pop of 10 entries with dec_ready=1 -> all 10 PCs appear in order, no bubbles after the first, level stays at 1.
- Flush: level=3, assert flush together with fetch_valid=1 (pc=0x40) -> next cycle level=0, dec_valid=0, 0x40 not stored; following push of 0x44 appears alone at the head.
- Async reset mid-stream: level=2, pulse reset between clock edges -> dec_valid=0 and level=0 before the next rising edge.
